// File: rtl/mesi_bus_pkg.sv
// rtl/mesi_bus_pkg.sv - shared types and defaults for the MESI snoop-bus controller
package mesi_bus_pkg;

    localparam int DEFAULT_NUM_CACHES = 4;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_RD,
        OP_RDX,
        OP_UPGR
    } bus_op_t;

    typedef enum logic [2:0] {
        IDLE,
        SNOOP,
        WB,
        MEM,
        DONE
    } snoop_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at a rotating index
module rr_arbiter #(
    parameter int NUM_CACHES = 4,
    parameter int IDX_W      = $clog2(NUM_CACHES)
) (
    input  logic [NUM_CACHES-1:0] i_req,
    input  logic [IDX_W-1:0]      i_start,
    output logic [NUM_CACHES-1:0] o_grant,
    output logic [IDX_W-1:0]      o_idx,
    output logic                  o_valid
);

    always_comb begin : pick
        int w_pos;
        logic [NUM_CACHES-1:0] w_oh;
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_pos   = 0;
        w_oh    = '0;
        // Scan farthest-first so the requester nearest the start index is written last.
        for (int k = NUM_CACHES - 1; k >= 0; k--) begin
            w_pos = (int'(i_start) + k) % NUM_CACHES;
            w_oh  = NUM_CACHES'(1) << w_pos;
            if (|(i_req & w_oh)) begin
                o_grant = w_oh;
                o_idx   = IDX_W'(w_pos);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mesi_snoop_bus_ctrl.sv
// rtl/mesi_snoop_bus_ctrl.sv - snoop-bus arbiter/sequencer for MESI caches
// Optional memory-ack watchdog enabled by defining MESI_SNOOP_TIMEOUT_EN.
module mesi_snoop_bus_ctrl
    import mesi_bus_pkg::*;
#(
    parameter int NUM_CACHES     = DEFAULT_NUM_CACHES,
    parameter int IDX_W          = $clog2(NUM_CACHES),
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic [NUM_CACHES-1:0] req_rd,
    input  logic [NUM_CACHES-1:0] req_rdx,
    input  logic [NUM_CACHES-1:0] req_upgr,
    input  logic [NUM_CACHES-1:0] flush_in,
    input  logic [NUM_CACHES-1:0] shared_in,
    output logic [NUM_CACHES-1:0] grant,
    output logic                  bus_rd_bcast,
    output logic                  bus_rdx_bcast,
    output logic                  bus_upgr_bcast,
    output logic [NUM_CACHES-1:0] snoop_mask,
    output logic                  c_out,
    output logic [NUM_CACHES-1:0] done,
    output logic                  mem_rd_req,
    output logic                  mem_wb_req,
    input  logic                  mem_ack,
`ifdef MESI_SNOOP_TIMEOUT_EN
    output logic                  timeout_err,
`endif
    output logic [IDX_W-1:0]      owner_idx
);

    snoop_state_t r_state;
    bus_op_t      r_op;
    logic [IDX_W-1:0] r_ptr;
    logic         r_c_lat;

    logic [NUM_CACHES-1:0] w_req_any;
    logic [NUM_CACHES-1:0] w_pick;
    logic [IDX_W-1:0]      w_pick_idx;
    logic                  w_pick_valid;
    bus_op_t               w_pick_op;
    logic                  w_snoop;
    logic                  w_timeout;

    assign w_req_any = req_rd | req_rdx | req_upgr;

    rr_arbiter #(
        .NUM_CACHES (NUM_CACHES),
        .IDX_W      (IDX_W)
    ) u_arb (
        .i_req   (w_req_any),
        .i_start (r_ptr),
        .o_grant (w_pick),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    assign w_pick_op = (|(req_rdx & w_pick))  ? OP_RDX  :
                       (|(req_upgr & w_pick)) ? OP_UPGR : OP_RD;

    assign w_snoop        = (r_state == SNOOP);
    assign bus_rd_bcast   = w_snoop && (r_op == OP_RD);
    assign bus_rdx_bcast  = w_snoop && (r_op == OP_RDX);
    assign bus_upgr_bcast = w_snoop && (r_op == OP_UPGR);
    assign snoop_mask     = w_snoop ? ~grant : '0;

`ifdef MESI_SNOOP_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;

    assign w_timeout = !mem_ack && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_cnt       <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            if (r_state == WB || r_state == MEM) begin
                r_cnt <= r_cnt + 1'b1;
                if (w_timeout) begin
                    timeout_err <= 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
    assign w_timeout        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state    <= IDLE;
            r_op       <= OP_NONE;
            r_ptr      <= '0;
            r_c_lat    <= 1'b0;
            grant      <= '0;
            owner_idx  <= '0;
            c_out      <= 1'b0;
            done       <= '0;
            mem_rd_req <= 1'b0;
            mem_wb_req <= 1'b0;
        end else begin
            done  <= '0;
            c_out <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        grant     <= w_pick;
                        owner_idx <= w_pick_idx;
                        r_op      <= w_pick_op;
                        r_state   <= SNOOP;
                    end
                end
                SNOOP: begin
                    r_c_lat <= |(shared_in & ~grant);
                    if (|(flush_in & ~grant)) begin
                        mem_wb_req <= 1'b1;
                        r_state    <= WB;
                    end else if (r_op == OP_UPGR) begin
                        done    <= grant;
                        r_state <= DONE;
                    end else begin
                        mem_rd_req <= 1'b1;
                        r_state    <= MEM;
                    end
                end
                WB, MEM: begin
                    if (mem_ack || w_timeout) begin
                        mem_rd_req <= 1'b0;
                        mem_wb_req <= 1'b0;
                        done       <= grant;
                        c_out      <= (r_op == OP_RD) && r_c_lat;
                        r_state    <= DONE;
                    end
                end
                DONE: begin
                    grant   <= '0;
                    r_ptr   <= (owner_idx == IDX_W'(NUM_CACHES - 1)) ? '0 : owner_idx + 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mesi_snoop_bus_ctrl.sv
// tb/tb_mesi_snoop_bus_ctrl.sv - self-checking bench for mesi_snoop_bus_ctrl
module tb_mesi_snoop_bus_ctrl;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rstb = 1'b1;
    logic [N-1:0] req_rd = '0, req_rdx = '0, req_upgr = '0, flush_in = '0, shared_in = '0;
    logic mem_ack = 1'b0;
    logic [N-1:0] grant, snoop_mask, done;
    logic bus_rd_bcast, bus_rdx_bcast, bus_upgr_bcast, c_out, mem_rd_req, mem_wb_req;
    logic [1:0] owner_idx;
`ifdef MESI_SNOOP_TIMEOUT_EN
    logic timeout_err;
`endif

    mesi_snoop_bus_ctrl #(.NUM_CACHES(N)) dut (
        .clk            (clk),
        .rstb           (rstb),
        .req_rd         (req_rd),
        .req_rdx        (req_rdx),
        .req_upgr       (req_upgr),
        .flush_in       (flush_in),
        .shared_in      (shared_in),
        .grant          (grant),
        .bus_rd_bcast   (bus_rd_bcast),
        .bus_rdx_bcast  (bus_rdx_bcast),
        .bus_upgr_bcast (bus_upgr_bcast),
        .snoop_mask     (snoop_mask),
        .c_out          (c_out),
        .done           (done),
        .mem_rd_req     (mem_rd_req),
        .mem_wb_req     (mem_wb_req),
        .mem_ack        (mem_ack),
`ifdef MESI_SNOOP_TIMEOUT_EN
        .timeout_err    (timeout_err),
`endif
        .owner_idx      (owner_idx)
    );

    always #5 clk = ~clk;

    // op: 1=Rd 2=RdX 3=Upgr; path: 0=none 1=memory read 2=write-back
    typedef struct {
        int owner;
        int op;
        int path;
        bit c;
    } txn_t;

    txn_t sb[$];
    int   done_log[$];
    int   model_ptr = 0;
    int   checks = 0;
    int   failures = 0;
    bit   last_c;
    bit   ack_en = 1'b0;
    int   ack_delay = 0;
    int   ack_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    function automatic txn_t predict(input logic [N-1:0] rd, input logic [N-1:0] rdx,
                                     input logic [N-1:0] up, input logic [N-1:0] sh,
                                     input logic [N-1:0] fl);
        txn_t t;
        logic [N-1:0] any, oh;
        any = rd | rdx | up;
        t.owner = -1;
        for (int k = 0; k < N; k++)
            if (t.owner < 0 && any[(model_ptr + k) % N]) t.owner = (model_ptr + k) % N;
        oh = N'(1) << t.owner;
        t.op = rdx[t.owner] ? 2 : (up[t.owner] ? 3 : 1);
        t.path = (|(fl & ~oh)) ? 2 : ((t.op == 3) ? 0 : 1);
        t.c = (t.op == 1) && (|(sh & ~oh));
        model_ptr = (t.owner + 1) % N;
        return t;
    endfunction

    always @(negedge clk) begin : ack_driver
        if (!ack_en || !(mem_rd_req || mem_wb_req)) begin
            mem_ack = 1'b0;
            ack_cnt = 0;
        end else begin
            mem_ack = (ack_cnt >= ack_delay);
            ack_cnt++;
        end
    end

    logic [N-1:0] prev_grant = '0, prev_done = '0;
    bit seen_rd = 1'b0, seen_wb = 1'b0;

    always @(negedge clk) begin : monitor
        txn_t e;
        logic [N-1:0] oh, nm;
        if (!rstb) begin
            prev_grant = '0;
            prev_done  = '0;
            seen_rd    = 1'b0;
            seen_wb    = 1'b0;
        end else begin
            if (prev_done != '0) chk("grant_after_done", grant, 0);
            chk("mem_req_excl", mem_rd_req & mem_wb_req, 0);
            if (grant != '0 && prev_grant == '0) begin
                seen_rd = 1'b0;
                seen_wb = 1'b0;
                if (sb.size() == 0) chk("unexpected_grant", grant, 0);
                else begin
                    e  = sb[0];
                    oh = N'(1) << e.owner;
                    nm = ~oh;
                    chk("grant", grant, oh);
                    chk("owner_idx", owner_idx, e.owner);
                    chk("bcast", {bus_rd_bcast, bus_rdx_bcast, bus_upgr_bcast},
                        (e.op == 1) ? 3'b100 : ((e.op == 2) ? 3'b010 : 3'b001));
                    chk("snoop_mask", snoop_mask, nm);
                end
            end else begin
                chk("bcast_quiet", {bus_rd_bcast, bus_rdx_bcast, bus_upgr_bcast, snoop_mask}, 0);
                if (grant != '0 && sb.size() > 0) begin
                    oh = N'(1) << sb[0].owner;
                    chk("grant_hold", grant, oh);
                end
            end
            if (mem_rd_req) seen_rd = 1'b1;
            if (mem_wb_req) seen_wb = 1'b1;
            if (done != '0) begin
                if (sb.size() == 0) chk("unexpected_done", done, 0);
                else begin
                    e  = sb.pop_front();
                    oh = N'(1) << e.owner;
                    chk("done", done, oh);
                    chk("c_out", c_out, e.c);
                    chk("path_rd", seen_rd, e.path == 1);
                    chk("path_wb", seen_wb, e.path == 2);
                    for (int i = 0; i < N; i++) if (done[i]) done_log.push_back(i);
                    last_c = c_out;
                end
            end
            prev_grant = grant;
            prev_done  = done;
        end
    end

    task automatic wait_empty();
        int c;
        c = 0;
        while (sb.size() > 0 && c < 300) begin
            @(negedge clk); #1;
            c++;
        end
        if (sb.size() > 0) begin
            chk("wait_done_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic wait_grant();
        int c;
        c = 0;
        while (grant == '0 && c < 50) begin
            @(negedge clk); #1;
            c++;
        end
        if (grant == '0) chk("wait_grant_timeout", 1, 0);
    endtask

    task automatic clear_inputs();
        req_rd = '0; req_rdx = '0; req_upgr = '0; shared_in = '0; flush_in = '0;
    endtask

    task automatic run(input logic [N-1:0] rd, input logic [N-1:0] rdx, input logic [N-1:0] up,
                       input logic [N-1:0] sh, input logic [N-1:0] fl, input int n_txn,
                       input int delay);
        ack_delay = delay;
        for (int i = 0; i < n_txn; i++) sb.push_back(predict(rd, rdx, up, sh, fl));
        req_rd = rd; req_rdx = rdx; req_upgr = up; shared_in = sh; flush_in = fl;
        wait_empty();
        clear_inputs();
        @(negedge clk); #1;
    endtask

    initial begin
        #1 rstb = 1'b0;
        #2;
        chk("rst_grant", grant, 0);
        chk("rst_done", done, 0);
        chk("rst_all", {grant, snoop_mask, done, bus_rd_bcast, bus_rdx_bcast, bus_upgr_bcast,
                        c_out, mem_rd_req, mem_wb_req, owner_idx}, 0);
        @(negedge clk); @(negedge clk); #1;
        rstb   = 1'b1;
        ack_en = 1'b1;

        // Fairness: everyone wants RdX, instant ack
        run('0, 4'b1111, '0, '0, '0, 5, 0);
        chk("fair_count", done_log.size(), 5);
        if (done_log.size() == 5) begin
            chk("fair_o0", done_log[0], 0);
            chk("fair_o1", done_log[1], 1);
            chk("fair_o2", done_log[2], 2);
            chk("fair_o3", done_log[3], 3);
            chk("fair_o4", done_log[4], 0);
        end

        // Single read, no sharers, pointer wraps back to 0
        run(4'b0001, '0, '0, '0, '0, 1, 3);
        chk("rd_single_owner", done_log[$], 0);
        chk("rd_single_c", last_c, 0);

        // Read hitting an M line in cache 1
        run(4'b0100, '0, '0, 4'b0010, 4'b0010, 1, 2);
        chk("rd_hitm_owner", done_log[$], 2);
        chk("rd_hitm_c", last_c, 1);

        // Upgrade, request dropped after grant
        sb.push_back(predict('0, '0, 4'b1000, '0, '0));
        req_upgr = 4'b1000;
        wait_grant();
        chk("upgr_mask", snoop_mask, 4'b0111);
        chk("upgr_bcast", {bus_rd_bcast, bus_rdx_bcast, bus_upgr_bcast}, 3'b001);
        req_upgr = '0;
        @(negedge clk); #1;
        chk("upgr_done", done, 4'b1000);
        chk("upgr_no_mem", {mem_rd_req, mem_wb_req}, 0);
        wait_empty();
        @(negedge clk); #1;

        // Requester's own flush/shared bits ignored
        run(4'b0001, '0, '0, 4'b0001, 4'b0001, 1, 1);
        // RdX beats Rd on the same cache; RdX never reports shared
        run(4'b0100, 4'b0100, '0, 4'b0001, '0, 1, 1);
        // Two readers with a sharer, rotation wraps 3 -> 0 -> 1
        run(4'b0011, '0, '0, 4'b1000, '0, 2, 1);
        // Upgrade with two flush bits (illegal) still goes through write-back
        run('0, '0, 4'b0010, '0, 4'b0101, 1, 0);

        // Async reset while waiting for memory
        ack_en = 1'b0;
        sb.push_back(predict(4'b0010, '0, '0, '0, '0));
        req_rd = 4'b0010;
        for (int c = 0; c < 20 && !mem_rd_req; c++) begin
            @(negedge clk); #1;
        end
        chk("rst_mid_in_mem", mem_rd_req, 1);
        @(negedge clk); @(negedge clk); #2;
        rstb = 1'b0;
        #1;
        chk("rst_mid_all", {grant, snoop_mask, done, bus_rd_bcast, bus_rdx_bcast, bus_upgr_bcast,
                            c_out, mem_rd_req, mem_wb_req, owner_idx}, 0);
        sb.delete();
        model_ptr = 0;
        sb.push_back(predict(4'b0010, '0, '0, '0, '0));
        @(negedge clk); #1;
        rstb      = 1'b1;
        ack_en    = 1'b1;
        ack_delay = 1;
        wait_empty();
        clear_inputs();
        chk("rst_after_owner", done_log[$], 1);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
